// File: rtl/tmem_ctl.sv
// Tagged-memory controller: address latch, 64b+tag array,
// atomic read-modify-write lock and absent-word bus time-out.
module tmem_ctl #(
  parameter int AW        = 20,
  parameter int POP_WORDS = 1 << 20,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   i_ad,
  input  logic [7:0]    i_tag,
  input  logic          i_astb,
  input  logic          i_atomic,
  input  logic          i_rd,
  input  logic          i_wr,
  output logic [63:0]   o_data,
  output logic [7:0]    o_tag,
  output logic          o_valid,
  output logic          o_timeout,
  output logic          o_locked,
  output logic [AW-1:0] waddr
);

  localparam int IW = (POP_WORDS > 1) ? $clog2(POP_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE, ADDR, READ, TOUT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          atomic_q, atomic_d;
  logic          lock_q, lock_d;
  logic          valid_q, valid_d;
  logic          tout_q, tout_d;
  logic [71:0]   data_q, data_d;
  logic          mem_we;
  logic          present;
  logic          rd_done;
  logic [AW-1:0] new_a;
  logic [IW-1:0] idx;

  logic [71:0] mem [POP_WORDS];

  assign new_a   = i_ad[AW-1:0];
  assign idx     = IW'(waddr_q);
  assign present = 32'(waddr_q) < 32'(POP_WORDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      atomic_q <= 1'b0;
      lock_q   <= 1'b0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      atomic_q <= atomic_d;
      lock_q   <= lock_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      data_q   <= data_d;
    end
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= {i_tag, i_ad};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    atomic_d = atomic_q;
    lock_d   = lock_q;
    valid_d  = 1'b0;
    tout_d   = 1'b0;
    data_d   = data_q;
    mem_we   = 1'b0;
    rd_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_astb) begin
          waddr_d  = new_a;
          atomic_d = i_atomic;
          if (new_a != waddr_q) lock_d = 1'b0;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (i_rd || i_wr) begin
          if (!present) begin
            state_d = TOUT;
            cnt_d   = 16'(TIMEOUT - 2);
          end else if (i_rd) begin
            if (RD_LAT == 1) rd_done = 1'b1;
            else begin
              state_d = READ;
              cnt_d   = 16'(RD_LAT - 2);
            end
          end else begin
            mem_we  = 1'b1;
            lock_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (i_astb) begin
          waddr_d  = new_a;
          atomic_d = i_atomic;
          if (new_a != waddr_q) lock_d = 1'b0;
        end
      end
      READ: begin
        if (cnt_q == '0) rd_done = 1'b1;
        else cnt_d = cnt_q - 16'd1;
      end
      TOUT: begin
        if (cnt_q == '0) begin
          tout_d  = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    if (rd_done) begin
      valid_d = 1'b1;
      data_d  = mem[idx];
      if (atomic_q) lock_d = 1'b1;
      state_d = IDLE;
    end
  end

  always_comb begin
    o_valid   = valid_q;
    o_timeout = tout_q;
    o_locked  = lock_q;
    o_data    = data_q[63:0];
    o_tag     = data_q[71:64];
    waddr     = waddr_q;
  end

endmodule

// File: doc/tmem_ctl.md
# tmem_ctl

Synthesizable tagged-memory controller that sits directly downstream of the `cpu` bus outputs and replaces the behavioural `tmemory` model. It has these jobs:
- latch the word address on the address strobe;
- serve 64-bit data plus 8-bit tag reads and writes from an internal array;
- hold an atomic read-modify-write lock;
- raise a bus time-out when the addressed word lies outside the populated region, which drives interrupts 12/13.

It exports the latched word address for the trace monitor.

## Interface
Parameters:
- `AW`, 20, word-address width (1M words).
- `POP_WORDS`, 1<<20, populated words; addresses ≥ POP_WORDS are absent.
- `RD_LAT`, 1, cycles from the `i_rd` cycle to `o_data` valid (1..4).
- `TIMEOUT`, 16, cycles an absent access waits before `o_timeout` (≥2).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_ad`  in  64  address (strobe cycle) or write data (write cycle), from cpu `o_ad`.
- `i_tag`  in  8  write tag.
- `i_astb`  in  1  address strobe.
- `i_atomic`  in  1  read-modify-write flag, sampled with `i_astb`.
- `i_rd`  in  1  read request.
- `i_wr`  in  1  write request.
- `o_data`  out  64  read data, to cpu `i_data`.
- `o_tag`  out  8  read tag, to cpu `i_tag`.
- `o_valid`  out  1  one-cycle pulse: `o_data`/`o_tag` valid.
- `o_timeout`  out  1  one-cycle pulse: access to an absent word.
- `o_locked`  out  1  atomic lock held.
- `waddr`  out  AW  latched word address.

## Operation
- Array: POP_WORDS × 72 bits ({tag, data}), not initialised by reset.
- Word address is `i_ad[AW-1:0]`. Higher bits of `i_ad` are ignored.

States and transitions:
- **IDLE**
  - `i_astb`: latch `waddr` and `atomic_q`, then go to ADDR.
  - `i_rd`/`i_wr` without a prior strobe are ignored.
- **ADDR**
  - `i_rd`:
    - Absent address: go to TOUT.
    - Present address: go to READ, loading the latency counter with RD_LAT.
  - `i_wr`:
    - Absent address: go to TOUT.
    - Present address: write `{i_tag, i_ad}` at `waddr` in the same edge and return to IDLE.
    - If `o_locked` is set, the write also clears the lock.
  - `i_astb`: re-latch the address and stay in ADDR. The last strobe wins.
  - `i_rd` and `i_wr` together: the read wins and the write is dropped.
- **READ**
  - Count down the latency counter.
  - At zero:
    - present `o_data`/`o_tag`;
    - pulse `o_valid`;
    - if `atomic_q`, set `o_locked`;
    - return to IDLE.
  - `o_data`/`o_tag` hold their value until the next read completes.
- **TOUT**
  - Count TIMEOUT cycles.
  - Then pulse `o_timeout`, clear `o_locked` and return to IDLE.
  - No array access occurs.

Lock rules:
- While `o_locked`=1, a strobe to a different address also clears the lock; it stays cleared even if no write follows.
- A strobe to the same address keeps the lock until that address is written.

Reset, at any time including mid-access:
- State goes to IDLE.
- `o_valid`, `o_timeout`, `o_locked` go to 0.
- `o_data`, `o_tag`, `waddr` go to 0.
- Array contents are preserved.

## Timing
- Strobe at cycle n → `waddr` valid at n+1.
- `i_rd` at cycle m (in ADDR) → `o_valid` pulse and data at m+RD_LAT. With RD_LAT=1, data appears the cycle after the request.
- Write takes effect at the edge ending the `i_wr` cycle. A read strobed the very next cycle returns the new value.
- Absent access: `i_rd`/`i_wr` at cycle m → `o_timeout` at m+TIMEOUT, one cycle wide.
- No pipelining: one access is outstanding at a time.
- `i_astb` during READ or TOUT is ignored; the CPU must not issue it.
- `o_valid` and `o_timeout` are never high together.

## Test plan
- Reset: assert `reset` mid-READ → all outputs 0 within the same cycle. After release, a strobe and read to 5 return the previous contents.
- Write/read: strobe 0x12345, write data 0x0123456789ABCDEF, tag 0x35; strobe 0x12345, read → `o_valid` 1 cycle later with that data and tag; `waddr`=0x12345.
- Latency sweep: RD_LAT=1,2,4 → `o_valid` at exactly m+RD_LAT, a single pulse each time.
- Absent word: POP_WORDS=0x40000; strobe 0x40000, write → `o_timeout` exactly 16 cycles later. The array is unchanged and the next access succeeds.
- Atomic: strobe 7 with `i_atomic`, read → `o_locked`=1. Writing word 7 clears it. Repeating with a strobe to 8 between the read and the write also clears it.
- Back-to-back: two strobes in a row (3 then 9), then a read → returns word 9. Simultaneous `i_rd`+`i_wr` → read performed, memory unchanged.
